bank_isu_sc_arb: RTL and testbench

//  Credit-aware round-robin arbiter between the three per-channel issue streams of a bank ISU and the single ISU->SC issue port.
//  - Read requests consume one xbar ROB credit per channel; writes are credit-free.
//  - The issue register drives SC; it holds a request until SC accepts it.

---
 rtl/bank_isu_pkg.sv | 27 ++
 rtl/bank_isu_credit_cnt.sv | 33 +++
 rtl/bank_isu_sc_arb.sv | 119 +++++++++++
 tb/tb_bank_isu_sc_arb.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/bank_isu_pkg.sv
// Shared types and helpers for the bank ISU -> SC issue arbiter.
// Holds the channel count, the channel id type and the round-robin picker.
package bank_isu_pkg;

   localparam int NUM_CH = 3;

   typedef logic [1:0] ch_id_t;

   // One-hot grant for the first eligible channel at or after ptr, wrapping.
   function automatic logic [NUM_CH-1:0] rr_pick(input logic [NUM_CH-1:0] eligible,
                                                 input ch_id_t           ptr);
      logic [NUM_CH-1:0] gnt;
      logic              found;
      int                idx;
      gnt   = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         idx = (int'(ptr) + i) % NUM_CH;
         if (!found && eligible[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
      return gnt;
   endfunction

endpackage

// File: rtl/bank_isu_credit_cnt.sv
// Per-channel xbar ROB credit counter with saturation at CREDIT_MAX and a
// sticky error flag for returns that would overflow it.
module bank_isu_credit_cnt #(
   parameter int CREDIT_MAX = 4,
   parameter int CW         = 3
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          dec,
   input  logic          inc,
   output logic [CW-1:0] count,
   output logic          err
);

   localparam logic [CW-1:0] MAX = CW'(CREDIT_MAX);

   // dec is only asserted when count is non-zero, so no underflow guard.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count <= MAX;
         err   <= 1'b0;
      end else if (dec && !inc) begin
         count <= count - CW'(1);
      end else if (inc && !dec) begin
         if (count == MAX) begin
            err <= 1'b1;
         end else begin
            count <= count + CW'(1);
         end
      end
   end

endmodule

// File: rtl/bank_isu_sc_arb.sv
// Credit-aware round-robin arbiter from three ISU channel streams to the SC issue port.
// Optional starvation priority is enabled with `define BANK_ISU_ARB_STARVE_EN.
module bank_isu_sc_arb
   import bank_isu_pkg::*;
#(
   parameter int PAYLOAD_W  = 64,
   parameter int CREDIT_MAX = 4,
   parameter int CW         = 3,
   parameter int STARVE_LIM = 16
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic [NUM_CH-1:0]           ch_req_valid_i,
   output logic [NUM_CH-1:0]           ch_req_ready_o,
   input  logic [NUM_CH-1:0]           ch_req_is_read_i,
   input  logic [NUM_CH*PAYLOAD_W-1:0] ch_req_payload_i,
   output logic                        sc_valid_o,
   input  logic                        sc_ready_i,
   output ch_id_t                      sc_ch_id_o,
   output logic [PAYLOAD_W-1:0]        sc_payload_o,
   input  logic [NUM_CH-1:0]           xbar_credit_ret_i,
   output logic [NUM_CH*CW-1:0]        ch_credit_o,
   output logic                        credit_err_o
);

   if (CREDIT_MAX >= (1 << CW) || STARVE_LIM < 1) begin : g_bad_cfg
      $error("bank_isu_sc_arb: CW too narrow for CREDIT_MAX or STARVE_LIM < 1");
   end

   logic [NUM_CH-1:0] cred_nz;
   logic [NUM_CH-1:0] eligible;
   logic [NUM_CH-1:0] pick;
   logic [NUM_CH-1:0] grant;
   logic [NUM_CH-1:0] cnt_err;
   logic              load;
   ch_id_t            rr_ptr;
   ch_id_t            grant_id;

   // Handshakes: a transfer happens on a cycle where valid && ready are both
   // high; valid never depends on ready, and the issue register holds its
   // contents while sc_valid_o && !sc_ready_i.
   assign eligible = ch_req_valid_i & (~ch_req_is_read_i | cred_nz);
   assign load     = ~sc_valid_o | sc_ready_i;

`ifdef BANK_ISU_ARB_STARVE_EN
   localparam int WW = $clog2(STARVE_LIM + 1);

   logic [WW-1:0]     wait_cnt [NUM_CH];
   logic [NUM_CH-1:0] starved;

   for (genvar n = 0; n < NUM_CH; n++) begin : g_starved
      assign starved[n] = eligible[n] && (wait_cnt[n] == WW'(STARVE_LIM));
   end

   // Starved channels override RR; lowest index wins among them.
   always_comb begin
      pick = rr_pick(eligible, rr_ptr);
      if (|starved) pick = starved & (~starved + NUM_CH'(1));
   end

   always_ff @(posedge clk_i) begin
      for (int n = 0; n < NUM_CH; n++) begin
         if (rst_i || grant[n]) begin
            wait_cnt[n] <= '0;
         end else if (eligible[n] && wait_cnt[n] != WW'(STARVE_LIM)) begin
            wait_cnt[n] <= wait_cnt[n] + WW'(1);
         end
      end
   end
`else
   assign pick = rr_pick(eligible, rr_ptr);
`endif

   assign grant          = load ? pick : '0;
   assign ch_req_ready_o = grant;

   always_comb begin
      grant_id = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (grant[i]) grant_id = ch_id_t'(i);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sc_valid_o   <= 1'b0;
         sc_ch_id_o   <= '0;
         sc_payload_o <= '0;
         rr_ptr       <= '0;
      end else if (load) begin
         if (|grant) begin
            sc_valid_o   <= 1'b1;
            sc_ch_id_o   <= grant_id;
            sc_payload_o <= ch_req_payload_i[int'(grant_id)*PAYLOAD_W +: PAYLOAD_W];
            rr_ptr       <= (grant_id == ch_id_t'(NUM_CH - 1)) ? '0 : grant_id + ch_id_t'(1);
         end else begin
            sc_valid_o <= 1'b0;
         end
      end
   end

   for (genvar n = 0; n < NUM_CH; n++) begin : g_credit
      bank_isu_credit_cnt #(
         .CREDIT_MAX (CREDIT_MAX),
         .CW         (CW)
      ) u_cnt (
         .clk_i (clk_i),
         .rst_i (rst_i),
         .dec   (grant[n] & ch_req_is_read_i[n]),
         .inc   (xbar_credit_ret_i[n]),
         .count (ch_credit_o[n*CW +: CW]),
         .err   (cnt_err[n])
      );
      assign cred_nz[n] = (ch_credit_o[n*CW +: CW] != '0);
   end

   assign credit_err_o = |cnt_err;

endmodule

// File: tb/tb_bank_isu_sc_arb.sv
// Self-checking bench for bank_isu_sc_arb: vector table plus an issue scoreboard.
// Starvation sequence is compiled in when BANK_ISU_ARB_STARVE_EN is defined.
module tb_bank_isu_sc_arb;

   localparam int PW = 64;
   localparam int CW = 3;

   logic          clk = 1'b0;
   logic          rst_i;
   logic [2:0]    ch_req_valid_i;
   logic [2:0]    ch_req_ready_o;
   logic [2:0]    ch_req_is_read_i;
   logic [3*PW-1:0] ch_req_payload_i;
   logic          sc_valid_o;
   logic          sc_ready_i;
   logic [1:0]    sc_ch_id_o;
   logic [PW-1:0] sc_payload_o;
   logic [2:0]    xbar_credit_ret_i;
   logic [3*CW-1:0] ch_credit_o;
   logic          credit_err_o;

   bank_isu_sc_arb #(.PAYLOAD_W(PW), .CREDIT_MAX(4), .CW(CW), .STARVE_LIM(16)) dut (
      .clk_i             (clk),
      .rst_i             (rst_i),
      .ch_req_valid_i    (ch_req_valid_i),
      .ch_req_ready_o    (ch_req_ready_o),
      .ch_req_is_read_i  (ch_req_is_read_i),
      .ch_req_payload_i  (ch_req_payload_i),
      .sc_valid_o        (sc_valid_o),
      .sc_ready_i        (sc_ready_i),
      .sc_ch_id_o        (sc_ch_id_o),
      .sc_payload_o      (sc_payload_o),
      .xbar_credit_ret_i (xbar_credit_ret_i),
      .ch_credit_o       (ch_credit_o),
      .credit_err_o      (credit_err_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] v;
      logic [2:0] rd;
      logic       rdy;
      logic [2:0] ret;
      logic [2:0] exp_ready;
      logic [8:0] exp_cred;
      logic       exp_err;
   } vec_t;

   vec_t            tbl[$];
   logic [PW+1:0]   exp_q[$];
   logic [PW+1:0]   cur_exp;
   logic            exp_valid;
   logic [PW-1:0]   pl[3];
   int              n_pass = 0;
   int              n_total = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
   endtask

   function automatic logic [8:0] cr(input int c0, input int c1, input int c2);
      return {3'(c2), 3'(c1), 3'(c0)};
   endfunction

   function automatic vec_t mk(input logic [2:0] v, input logic [2:0] rd, input logic rdy,
                               input logic [2:0] ret, input logic [2:0] er,
                               input logic [8:0] ec, input logic ee);
      vec_t t;
      t.v = v; t.rd = rd; t.rdy = rdy; t.ret = ret;
      t.exp_ready = er; t.exp_cred = ec; t.exp_err = ee;
      return t;
   endfunction

   function automatic logic [1:0] oh2id(input logic [2:0] oh);
      return oh[2] ? 2'd2 : (oh[1] ? 2'd1 : 2'd0);
   endfunction

   // Entered 1 time unit after a rising edge; leaves 1 unit after the next one.
   task automatic apply(input vec_t t);
      logic [1:0] id;
      ch_req_valid_i    = t.v;
      ch_req_is_read_i  = t.rd;
      sc_ready_i        = t.rdy;
      xbar_credit_ret_i = t.ret;
      for (int n = 0; n < 3; n++) pl[n] = {$urandom, $urandom};
      ch_req_payload_i = {pl[2], pl[1], pl[0]};
      #1;
      chk("ready", 64'(ch_req_ready_o), 64'(t.exp_ready));
      if (t.exp_ready != 3'b000) begin
         id = oh2id(t.exp_ready);
         exp_q.push_back({id, pl[id]});
      end
      @(posedge clk);
      #1;
      if (t.exp_ready != 3'b000) begin
         exp_valid = 1'b1;
         if (exp_q.size() == 0) chk("scoreboard_empty", 64'd1, 64'd0);
         else cur_exp = exp_q.pop_front();
      end else if (!exp_valid || t.rdy) begin
         exp_valid = 1'b0;
      end
      chk("sc_valid", 64'(sc_valid_o), 64'(exp_valid));
      if (exp_valid) begin
         chk("sc_ch_id", 64'(sc_ch_id_o), 64'(cur_exp[PW+1:PW]));
         chk("sc_payload", sc_payload_o, cur_exp[PW-1:0]);
      end
      chk("credits", 64'(ch_credit_o), 64'(t.exp_cred));
      chk("credit_err", 64'(credit_err_o), 64'(t.exp_err));
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      ch_req_valid_i = '0; ch_req_is_read_i = '0; sc_ready_i = 1'b0;
      xbar_credit_ret_i = '0; ch_req_payload_i = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_sc_valid", 64'(sc_valid_o), 64'd0);
      chk("rst_sc_ch_id", 64'(sc_ch_id_o), 64'd0);
      chk("rst_sc_payload", sc_payload_o, 64'd0);
      chk("rst_ready", 64'(ch_req_ready_o), 64'd0);
      chk("rst_credits", 64'(ch_credit_o), 64'(cr(4, 4, 4)));
      chk("rst_credit_err", 64'(credit_err_o), 64'd0);
      rst_i = 1'b0;
      exp_valid = 1'b0;
      exp_q.delete();
   endtask

   initial begin
      do_reset();

      // Reads on all channels until every credit is drained.
      tbl.push_back(mk(3'b111, 3'b111, 1, 3'b000, 3'b001, cr(3, 4, 4), 0));
      tbl.push_back(mk(3'b111, 3'b111, 1, 3'b000, 3'b010, cr(3, 3, 4), 0));
      tbl.push_back(mk(3'b111, 3'b111, 1, 3'b000, 3'b100, cr(3, 3, 3), 0));
      tbl.push_back(mk(3'b111, 3'b111, 1, 3'b000, 3'b001, cr(2, 3, 3), 0));
      tbl.push_back(mk(3'b111, 3'b111, 1, 3'b000, 3'b010, cr(2, 2, 3), 0));
      tbl.push_back(mk(3'b111, 3'b111, 1, 3'b000, 3'b100, cr(2, 2, 2), 0));
      tbl.push_back(mk(3'b111, 3'b111, 1, 3'b000, 3'b001, cr(1, 2, 2), 0));
      tbl.push_back(mk(3'b111, 3'b111, 1, 3'b000, 3'b010, cr(1, 1, 2), 0));
      tbl.push_back(mk(3'b111, 3'b111, 1, 3'b000, 3'b100, cr(1, 1, 1), 0));
      tbl.push_back(mk(3'b111, 3'b111, 1, 3'b000, 3'b001, cr(0, 1, 1), 0));
      tbl.push_back(mk(3'b111, 3'b111, 1, 3'b000, 3'b010, cr(0, 0, 1), 0));
      tbl.push_back(mk(3'b111, 3'b111, 1, 3'b000, 3'b100, cr(0, 0, 0), 0));
      tbl.push_back(mk(3'b111, 3'b111, 1, 3'b000, 3'b000, cr(0, 0, 0), 0));
      // Credit return unblocks a pending ch1 read.
      tbl.push_back(mk(3'b010, 3'b111, 1, 3'b010, 3'b000, cr(0, 1, 0), 0));
      tbl.push_back(mk(3'b010, 3'b010, 1, 3'b000, 3'b010, cr(0, 0, 0), 0));
      // Writes stay eligible at zero credit; a zero-credit read never wins.
      tbl.push_back(mk(3'b001, 3'b000, 1, 3'b000, 3'b001, cr(0, 0, 0), 0));
      tbl.push_back(mk(3'b011, 3'b000, 1, 3'b000, 3'b010, cr(0, 0, 0), 0));
      tbl.push_back(mk(3'b011, 3'b000, 1, 3'b000, 3'b001, cr(0, 0, 0), 0));
      tbl.push_back(mk(3'b011, 3'b001, 1, 3'b000, 3'b010, cr(0, 0, 0), 0));
      tbl.push_back(mk(3'b011, 3'b001, 1, 3'b000, 3'b010, cr(0, 0, 0), 0));
      tbl.push_back(mk(3'b001, 3'b001, 1, 3'b000, 3'b000, cr(0, 0, 0), 0));
      // ch2: returns to 2, grant+return same cycle, refill, overflow return.
      tbl.push_back(mk(3'b000, 3'b000, 1, 3'b100, 3'b000, cr(0, 0, 1), 0));
      tbl.push_back(mk(3'b000, 3'b000, 1, 3'b100, 3'b000, cr(0, 0, 2), 0));
      tbl.push_back(mk(3'b100, 3'b100, 1, 3'b100, 3'b100, cr(0, 0, 2), 0));
      tbl.push_back(mk(3'b000, 3'b000, 1, 3'b100, 3'b000, cr(0, 0, 3), 0));
      tbl.push_back(mk(3'b000, 3'b000, 1, 3'b100, 3'b000, cr(0, 0, 4), 0));
      tbl.push_back(mk(3'b000, 3'b000, 1, 3'b100, 3'b000, cr(0, 0, 4), 1));
      // SC back-pressure: register holds for 5 cycles, then back-to-back.
      tbl.push_back(mk(3'b100, 3'b000, 1, 3'b000, 3'b100, cr(0, 0, 4), 1));
      for (int i = 0; i < 5; i++)
         tbl.push_back(mk(3'b111, 3'b000, 0, 3'b000, 3'b000, cr(0, 0, 4), 1));
      tbl.push_back(mk(3'b111, 3'b000, 1, 3'b000, 3'b001, cr(0, 0, 4), 1));
      tbl.push_back(mk(3'b000, 3'b000, 1, 3'b000, 3'b000, cr(0, 0, 4), 1));
      // Leave an issue stalled in the register before the mid-run reset.
      tbl.push_back(mk(3'b010, 3'b000, 1, 3'b000, 3'b010, cr(0, 0, 4), 1));
      tbl.push_back(mk(3'b000, 3'b000, 0, 3'b000, 3'b000, cr(0, 0, 4), 1));

      for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

      // Mid-operation reset drops the stalled issue and clears the sticky error.
      do_reset();
      apply(mk(3'b111, 3'b011, 1, 3'b000, 3'b001, cr(3, 4, 4), 0));

`ifdef BANK_ISU_ARB_STARVE_EN
      do_reset();
      apply(mk(3'b110, 3'b000, 1, 3'b000, 3'b010, cr(4, 4, 4), 0));
      for (int i = 0; i < 16; i++)
         apply(mk(3'b111, 3'b000, 0, 3'b000, 3'b000, cr(4, 4, 4), 0));
      // RR pointer sits at ch2, but ch0 is starved and lowest-indexed.
      apply(mk(3'b111, 3'b000, 1, 3'b000, 3'b001, cr(4, 4, 4), 0));
      apply(mk(3'b111, 3'b000, 1, 3'b000, 3'b010, cr(4, 4, 4), 0));
      apply(mk(3'b111, 3'b000, 1, 3'b000, 3'b100, cr(4, 4, 4), 0));
      apply(mk(3'b111, 3'b000, 1, 3'b000, 3'b001, cr(4, 4, 4), 0));
`endif

      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
